// File: rtl/udc_pkg.sv
// rtl/udc_pkg.sv - shared constants and helpers for the up/down counter
package udc_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Bits needed to hold 0..v-1; v is at least 2 for every caller.
    function automatic int unsigned udc_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/udc_prescaler.sv
// rtl/udc_prescaler.sv - step qualifier: one tick every PRESCALE enabled cycles
module udc_prescaler
    import udc_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     PW   = udc_clog2(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down counter with limit, load, wrap/saturate and event flags
// Optional prescaler compiled in with UDC_PRESCALE_EN.
module updown_counter_mod
    import udc_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             UP_DOWN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             evt_sticky
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             sticky_q, sticky_d;
    logic             step;

`ifdef UDC_PRESCALE_EN
    logic tick;

    udc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign step = en & ~load & tick;
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign step = en & ~load;
`endif

    always_comb begin
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        sticky_d = sticky_q;
        if (load) begin
            count_d  = (load_val > limit) ? limit : load_val;
            sticky_d = 1'b0;
        end else if (step) begin
            // A lowered limit pulls an out-of-range count back silently on its next step.
            if (count_q > limit) begin
                count_d = limit;
            end else if (UP_DOWN == DIR_UP) begin
                if (count_q == limit) begin
                    ovf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? limit : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    unf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? '0 : limit;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            sticky_d = sticky_q | ovf_d | unf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= WIDTH'(RESET_VAL);
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    assign count      = count_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign evt_sticky = sticky_q;

endmodule
